// File: rtl/sip_pkg.sv
// Shared constants and payload types for the synaptic input processor.
package sip_pkg;

  localparam int unsigned N_SYN     = 16;
  localparam int unsigned W_WIDTH   = 4;
  localparam int unsigned V_WIDTH   = 8;
  localparam int unsigned THRESHOLD = 64;
  localparam int unsigned LEAK      = 1;
  localparam int unsigned SEL_WIDTH = 4;

  typedef logic [W_WIDTH-1:0]   weight_t;
  typedef logic [V_WIDTH-1:0]   vmem_t;
  typedef logic [SEL_WIDTH-1:0] sel_t;

  // One synapse event per clock, handed from the scanner to the neuron.
  typedef struct packed {
    logic    run;     // scan running this cycle
    logic    active;  // gated and spiking: apply the weight
    logic    excit;   // 1 = add, 0 = subtract
    weight_t weight;
    logic    last;    // final synapse of the scan, leak applies
  } syn_event_t;

endpackage

// File: rtl/synaptic_input_processor_if.sv
// Control, spike/polarity inputs and scan outputs of the synaptic input processor.
interface synaptic_input_processor_if;
  import sip_pkg::*;

  logic             write;
  logic             st_and;
  logic             ct_and;
  logic             st;
  logic             ct;
  logic [N_SYN-1:0] parallel_spike_in;
  logic [N_SYN-1:0] parallel_ein;
  logic             flush_weight;
  logic             flush_ein;
  logic             flush_spike;
  logic             spike;
  sel_t             select;

  modport master (
    output write, st_and, ct_and, st, ct, parallel_spike_in, parallel_ein,
    input  flush_weight, flush_ein, flush_spike, spike, select
  );

  modport slave (
    input  write, st_and, ct_and, st, ct, parallel_spike_in, parallel_ein,
    output flush_weight, flush_ein, flush_spike, spike, select
  );

endinterface

// File: rtl/sip_lif_neuron.sv
// Leaky integrate-and-fire membrane: saturating/clamping integration, end-of-scan leak, fire.
module sip_lif_neuron
  import sip_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  syn_event_t ev_i,
  output logic       spike_o
);

  vmem_t                v_q, v_d;
  vmem_t                v_syn_c;
  vmem_t                w_ext_c;
  logic [V_WIDTH:0]     sum_c;
  logic                 fire_c;
  logic                 spike_q, spike_d;

  always_comb begin
    w_ext_c = V_WIDTH'(ev_i.weight);
    sum_c   = {1'b0, v_q} + (V_WIDTH+1)'(ev_i.weight);
    v_syn_c = v_q;
    if (ev_i.active) begin
      if (ev_i.excit) v_syn_c = sum_c[V_WIDTH] ? '1 : sum_c[V_WIDTH-1:0];
      else            v_syn_c = (v_q > w_ext_c) ? v_q - w_ext_c : '0;
    end
    fire_c = (v_syn_c >= V_WIDTH'(THRESHOLD));
  end

  // Fire wins over leak; an idle scan freezes the membrane.
  always_comb begin
    v_d     = v_q;
    spike_d = 1'b0;
    if (ev_i.run) begin
      if (fire_c) begin
        v_d     = '0;
        spike_d = 1'b1;
      end else if (ev_i.last) begin
        v_d = (v_syn_c >= V_WIDTH'(LEAK)) ? v_syn_c - V_WIDTH'(LEAK) : '0;
      end else begin
        v_d = v_syn_c;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      spike_q <= spike_d;
    end
  end

  assign spike_o = spike_q;

endmodule

// File: rtl/synaptic_input_processor.sv
// Synapse scanner: select counter, spike/polarity snapshots, weight table and gating.
module synaptic_input_processor
  import sip_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        reset_i,
  synaptic_input_processor_if.slave   bus_if
);

  sel_t             sel_q, sel_d;
  logic [N_SYN-1:0] spk_q, spk_d;
  logic [N_SYN-1:0] ein_q, ein_d;
  weight_t          w_q [N_SYN];
  logic             last_c;
  logic             en_c;
  syn_event_t       ev_c;
  logic             spike_w;

  assign last_c = bus_if.write && (sel_q == sel_t'(N_SYN - 1));
  assign en_c   = (bus_if.st_and & bus_if.st) | (bus_if.ct_and & bus_if.ct);

  // Snapshots refresh while idle and at the end of each scan.
  always_comb begin
    sel_d = sel_q;
    spk_d = spk_q;
    ein_d = ein_q;
    if (bus_if.write) sel_d = sel_q + sel_t'(1);
    if (!bus_if.write || last_c) begin
      spk_d = bus_if.parallel_spike_in;
      ein_d = bus_if.parallel_ein;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sel_q <= '0;
      spk_q <= bus_if.parallel_spike_in;
      ein_q <= bus_if.parallel_ein;
      for (int unsigned i = 0; i < N_SYN; i++) w_q[i] <= weight_t'(i);
    end else begin
      sel_q <= sel_d;
      spk_q <= spk_d;
      ein_q <= ein_d;
    end
  end

  always_comb begin
    ev_c.run    = bus_if.write;
    ev_c.active = en_c & spk_q[sel_q];
    ev_c.excit  = ein_q[sel_q];
    ev_c.weight = w_q[sel_q];
    ev_c.last   = last_c;
  end

  sip_lif_neuron u_neuron (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ev_i    (ev_c),
    .spike_o (spike_w)
  );

  assign bus_if.flush_weight = last_c;
  assign bus_if.flush_ein    = last_c;
  assign bus_if.flush_spike  = last_c;
  assign bus_if.spike        = spike_w;
  assign bus_if.select       = sel_q;

endmodule

// File: tb/tb_synaptic_input_processor.sv
// Scoreboard bench: a behavioural LIF model queues per-cycle expectations, checked after each edge.
module tb_synaptic_input_processor;

  typedef struct packed {
    logic [3:0] sel;
    logic       spk;
    logic [7:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   flush_cnt = 0;
  exp_t sb_q[$];

  int          m_sel = 0;
  int          m_v = 0;
  logic        m_spike = 1'b0;
  logic [15:0] m_spk = '0;
  logic [15:0] m_ein = '0;

  synaptic_input_processor_if bif ();

  synaptic_input_processor dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus_if  (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: check flush, model the edge, push expectation, then pop and compare.
  task automatic tick();
    exp_t e;
    exp_t o;
    int   s;
    int   val;
    logic fl;
    #1;
    fl = bif.write && (m_sel == 15);
    if (bif.flush_weight === 1'b1) flush_cnt++;
    check("flush_weight", 32'(bif.flush_weight), 32'(fl));
    check("flush_ein",    32'(bif.flush_ein),    32'(fl));
    check("flush_spike",  32'(bif.flush_spike),  32'(fl));
    if (rst) begin
      m_sel = 0; m_v = 0; m_spike = 1'b0;
      m_spk = bif.parallel_spike_in; m_ein = bif.parallel_ein;
    end else if (bif.write) begin
      s   = m_sel;
      val = m_v;
      if (((bif.st_and && bif.st) || (bif.ct_and && bif.ct)) && m_spk[s])
        val = m_ein[s] ? val + s : val - s;
      if (val > 255) val = 255;
      if (val < 0)   val = 0;
      if (val >= 64) begin
        m_v = 0; m_spike = 1'b1;
      end else begin
        if (s == 15 && val > 0) val = val - 1;
        m_v = val; m_spike = 1'b0;
      end
      m_sel = (s + 1) % 16;
      if (s == 15) begin
        m_spk = bif.parallel_spike_in; m_ein = bif.parallel_ein;
      end
    end else begin
      m_spike = 1'b0;
      m_spk = bif.parallel_spike_in; m_ein = bif.parallel_ein;
    end
    e.sel = 4'(m_sel);
    e.spk = m_spike;
    e.v   = 8'(m_v);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check("select", 32'(bif.select), 32'(o.sel));
    check("spike",  32'(bif.spike),  32'(o.spk));
    check("v",      32'(dut.u_neuron.v_q), 32'(o.v));
  endtask

  task automatic set_inputs(input logic [15:0] sp, input logic [15:0] ei,
                            input logic sta, input logic cta, input logic s, input logic c);
    bif.parallel_spike_in = sp;
    bif.parallel_ein      = ei;
    bif.st_and = sta; bif.ct_and = cta; bif.st = s; bif.ct = c;
  endtask

  initial begin
    int n_sp;
    int sp_at;
    bif.write = 1'b0;
    set_inputs(16'hAAAA, 16'hFFF0, 1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    tick();
    check("rst_select", 32'(bif.select), 32'd0);
    check("rst_spike",  32'(bif.spike),  32'd0);
    check("rst_v",      32'(dut.u_neuron.v_q), 32'd0);

    // Scan 1 and 2 of the reference stimulus
    rst = 1'b0;
    bif.write = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    check("scan1_v", 32'(dut.u_neuron.v_q), 32'd59);
    n_sp = 0; sp_at = -1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (bif.spike === 1'b1) begin n_sp++; sp_at = k; end
    end
    check("scan2_nspk", 32'(n_sp), 32'd1);
    check("scan2_spk_at", 32'(sp_at), 32'd7);
    check("scan2_v", 32'(dut.u_neuron.v_q), 32'd47);

    // New inputs presented in the select=15 cycle take effect next scan
    for (int k = 0; k < 16; k++) begin
      if (k == 15) set_inputs(16'hF000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    check("flush_per_scan", 32'(flush_cnt), 32'd3);
    for (int k = 0; k < 16; k++) tick();

    // Gating off: leak-only decay to zero
    set_inputs(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    n_sp = 0;
    for (int k = 0; k < 64 * 16; k++) begin
      tick();
      if (bif.spike === 1'b1) n_sp++;
    end
    check("decay_nspk", 32'(n_sp), 32'd0);
    check("decay_v", 32'(dut.u_neuron.v_q), 32'd0);

    // Idle freezes select and V
    bif.write = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_inputs(16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
    end

    // All-inhibitory from zero
    set_inputs(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    bif.write = 1'b1;
    for (int k = 0; k < 32; k++) tick();
    check("inhib_v", 32'(dut.u_neuron.v_q), 32'd0);

    // Reset exactly when scan 2 would fire: no spike
    set_inputs(16'hAAAA, 16'hFFF0, 1'b0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 23; k++) tick();
    check("pre_rst_sel7", 32'(bif.select), 32'd7);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst7_spike", 32'(bif.spike), 32'd0);
    check("rst7_select", 32'(bif.select), 32'd0);

    // Reset during select=9
    for (int k = 0; k < 25; k++) tick();
    check("pre_rst_sel9", 32'(bif.select), 32'd9);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst9_select", 32'(bif.select), 32'd0);
    check("rst9_v", 32'(dut.u_neuron.v_q), 32'd0);
    check("rst9_spike", 32'(bif.spike), 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bif.write = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 99) == 0);
      set_inputs(16'($urandom), 16'($urandom | 32'h0000_FF00), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
